// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: req/ack instruction-memory bus between the fetch unit and imem
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;
  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and one-word-at-a-time instruction fetch with redirect and halt
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus,
  input  logic                i_fetch_en,
  output logic [31:0]         o_instr_out,
  output logic                o_ir_write,
  input  logic                i_dec_ready,
  input  logic                i_pc_load,
  input  logic [ADDR_W-1:0]   i_pc_load_val,
  output logic [ADDR_W-1:0]   o_pc,
  output logic                o_halted
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DEC, HALT} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_pc, r_pend, w_pend, w_tgt;
  logic              r_pend_v, w_pend_v, r_req, r_ir_write, r_halted, w_ack;
  logic [31:0]       r_instr;
  assign w_tgt = i_pc_load_val & ~ADDR_W'(3);
  assign w_ack = (r_state == REQ) && bus.ack;
  always_comb begin
    w_next   = r_state;
    w_pc     = r_pc;
    w_pend   = r_pend;
    w_pend_v = r_pend_v;
    case (r_state)
      IDLE: begin
        w_next = i_fetch_en ? REQ : IDLE;
        w_pc   = i_pc_load ? w_tgt : r_pc;
      end
      REQ: begin
        // redirects arriving mid-request are parked until the word returns
        if (bus.ack) begin
          w_next   = bus.rdata[0] ? HALT : WAIT_DEC;
          w_pend_v = 1'b0;
          w_pc     = bus.rdata[0] ? r_pc :
                     i_pc_load    ? w_tgt :
                     r_pend_v     ? r_pend : r_pc + ADDR_W'(PC_STEP);
        end else if (i_pc_load) begin
          w_pend_v = 1'b1;
          w_pend   = w_tgt;
        end
      end
      WAIT_DEC: begin
        w_next = !i_dec_ready ? WAIT_DEC : i_fetch_en ? REQ : IDLE;
        w_pc   = i_pc_load ? w_tgt : r_pc;
      end
      default: w_next = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_pend_v   <= 1'b0;
      r_req      <= 1'b0;
      r_ir_write <= 1'b0;
      r_halted   <= 1'b0;
      r_instr    <= '0;
    end else begin
      r_state    <= w_next;
      r_pc       <= w_pc;
      r_pend     <= w_pend;
      r_pend_v   <= w_pend_v;
      r_req      <= (w_next == REQ);
      r_ir_write <= w_ack;
      r_halted   <= (w_next == HALT);
      if (w_ack) r_instr <= bus.rdata;
    end
  end
  assign bus.req     = r_req;
  assign bus.addr    = r_pc;
  assign o_pc        = r_pc;
  assign o_instr_out = r_instr;
  assign o_ir_write  = r_ir_write;
  assign o_halted    = r_halted;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch, halt, redirect, async reset and wrap scenarios
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        dec_ready = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;
  logic [31:0] instr_out, pc;
  logic        ir_write, halted;
  int          errors = 0;
  int          checks = 0;
  instr_fetch_unit_if #(.ADDR_W(32)) bus ();
  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_fetch_en(fetch_en),
    .o_instr_out(instr_out), .o_ir_write(ir_write), .i_dec_ready(dec_ready),
    .i_pc_load(pc_load), .i_pc_load_val(pc_load_val), .o_pc(pc), .o_halted(halted)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(bus.req), 32'd1);
  endtask
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d, input int dly);
    wait_req(tag);
    check({tag, "_addr"}, bus.addr, a);
    repeat (dly) @(negedge clk);
    bus.ack = 1'b1;
    bus.rdata = d;
    @(negedge clk);
    bus.ack = 1'b0;
    check({tag, "_irw"}, 32'(ir_write), 32'd1);
    check({tag, "_instr"}, instr_out, d);
  endtask
  task automatic decode();
    @(negedge clk);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
  endtask
  initial begin
    bus.ack = 1'b0;
    bus.rdata = '0;
    #1;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_irw", 32'(ir_write), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_en = 1'b1;
    // sequential fetches, then halt word at 0x8
    fetch("seq0", 32'h0, 32'h1111_1110, 2);
    check("seq0_pc", pc, 32'h4);
    decode();
    fetch("seq1", 32'h4, 32'h2222_2220, 2);
    check("seq1_pc", pc, 32'h8);
    decode();
    fetch("halt", 32'h8, 32'h0000_0001, 2);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", pc, 32'h8);
    dec_ready = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 32'h200;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_noreq", 32'(bus.req), 32'd0);
      check("halt_noirw", 32'(ir_write), 32'd0);
    end
    dec_ready = 1'b0;
    pc_load = 1'b0;
    check("halt_pc_hold", pc, 32'h8);
    check("halt_stays", 32'(halted), 32'd1);
    // asynchronous reset out of HALT, during an IR_Write pulse, and mid-request
    #2 rst_n = 1'b0;
    #1;
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch("r0", 32'h0, 32'h3333_3330, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_irw", 32'(ir_write), 32'd0);
    check("arst_instr", instr_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_req("r1");
    check("r1_addr", bus.addr, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // redirect in WAIT_DEC together with dec_ready, low bits forced to zero
    fetch("t3a", 32'h0, 32'h4444_4440, 1);
    @(negedge clk);
    dec_ready = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 32'h103;
    @(negedge clk);
    dec_ready = 1'b0;
    pc_load = 1'b0;
    fetch("t3b", 32'h100, 32'h5555_5550, 0);
    check("t3b_pc", pc, 32'h104);
    // redirect during REQ; the later load overwrites the pending target
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_req("t4");
    pc_load = 1'b1;
    pc_load_val = 32'h20;
    @(negedge clk);
    pc_load_val = 32'h40;
    @(negedge clk);
    pc_load = 1'b0;
    check("t4_addr_hold", bus.addr, 32'h0);
    @(negedge clk);
    check("t4_addr_hold2", bus.addr, 32'h0);
    bus.ack = 1'b1;
    bus.rdata = 32'h6666_6660;
    @(negedge clk);
    bus.ack = 1'b0;
    check("t4_irw", 32'(ir_write), 32'd1);
    check("t4_pc", pc, 32'h40);
    decode();
    fetch("t4b", 32'h40, 32'h7777_7770, 1);
    check("t4b_pc", pc, 32'h44);
    // wrap at the top of the address space, then drop fetch_en
    @(negedge clk);
    dec_ready = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 32'hFFFF_FFFC;
    @(negedge clk);
    dec_ready = 1'b0;
    pc_load = 1'b0;
    fetch("wrap", 32'hFFFF_FFFC, 32'h8888_8880, 1);
    check("wrap_pc", pc, 32'h0);
    fetch_en = 1'b0;
    decode();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_noreq", 32'(bus.req), 32'd0);
    end
    fetch_en = 1'b1;
    @(negedge clk);
    fetch("resume", 32'h0, 32'h9999_9990, 1);
    check("resume_pc", pc, 32'h4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
